// File: rtl/red_pitaya_fads_sort_pulse_pkg.sv
// Shared constants for the FADS sort-pulse actuator: register offsets,
// state encodings and reset defaults.
package red_pitaya_fads_sort_pulse_pkg;

    localparam logic [19:0] REG_CTRL        = 20'h00;
    localparam logic [19:0] REG_DELAY       = 20'h04;
    localparam logic [19:0] REG_DURATION    = 20'h08;
    localparam logic [19:0] REG_HALF_PERIOD = 20'h0C;
    localparam logic [19:0] REG_AMPLITUDE   = 20'h10;
    localparam logic [19:0] REG_HOLDOFF     = 20'h14;
    localparam logic [19:0] REG_FIRED_CNT   = 20'h18;
    localparam logic [19:0] REG_DROPPED_CNT = 20'h1C;
    localparam logic [19:0] REG_STATUS      = 20'h20;

    localparam logic [31:0] DEF_DURATION    = 32'd1000;
    localparam logic [31:0] DEF_HALF_PERIOD = 32'd50;
    localparam logic [31:0] DEF_HOLDOFF     = 32'd1000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_FIRE    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

endpackage

// File: rtl/red_pitaya_fads_burst_gen.sv
// Gated square-wave generator: while run is high emits +amp / (-amp or 0),
// toggling every max(half_period,1) samples, starting on the positive phase.
module red_pitaya_fads_burst_gen #(
    parameter int DWT = 14,
    parameter int HPW = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  run,
    input  logic signed [DWT-1:0] amp,
    input  logic        [HPW-1:0] half_period,
    input  logic                  bipolar,
    output logic signed [DWT-1:0] sample
);

    localparam logic signed [DWT-1:0] AMP_MIN = {1'b1, {(DWT-1){1'b0}}};
    localparam logic signed [DWT-1:0] AMP_MAX = {1'b0, {(DWT-1){1'b1}}};

    logic        [HPW-1:0] hp_cnt_reg;
    logic                  phase_reg;
    logic        [HPW-1:0] hp_last;
    logic signed [DWT-1:0] low_level;

    // Negating the most negative code would wrap, so it clips to full scale.
    always_comb begin
        hp_last   = (half_period == '0) ? '0 : half_period - HPW'(1);
        low_level = '0;
        if (bipolar)
            low_level = (amp == AMP_MIN) ? AMP_MAX : -amp;
    end

    always_ff @(posedge clk) begin
        if (!rstn || !run) begin
            hp_cnt_reg <= '0;
            phase_reg  <= 1'b1;
            sample     <= '0;
        end else begin
            sample <= phase_reg ? amp : low_level;
            if (hp_cnt_reg == hp_last) begin
                hp_cnt_reg <= '0;
                phase_reg  <= ~phase_reg;
            end else begin
                hp_cnt_reg <= hp_cnt_reg + HPW'(1);
            end
        end
    end

endmodule

// File: rtl/red_pitaya_fads_sort_pulse.sv
// FADS sort actuator: trigger -> delay -> square-wave burst -> holdoff,
// with a system-bus register bank and fired/dropped event counters.
module red_pitaya_fads_sort_pulse
    import red_pitaya_fads_sort_pulse_pkg::*;
#(
    parameter int DWT = 14,
    parameter int MEM = 32,
    parameter int HPW = 16
) (
    input  logic                  adc_clk_i,
    input  logic                  adc_rstn_i,
    input  logic                  sort_trig_i,
    output logic signed [DWT-1:0] dac_o,
    output logic                  busy_o,
    input  logic           [31:0] sys_addr,
    input  logic           [31:0] sys_wdata,
    input  logic            [3:0] sys_sel,
    input  logic                  sys_wen,
    input  logic                  sys_ren,
    output logic           [31:0] sys_rdata,
    output logic                  sys_err,
    output logic                  sys_ack
);

    localparam logic [MEM-1:0] ONE = MEM'(1);

    state_t                state_reg;
    logic        [MEM-1:0] tmr_reg;
    logic        [MEM-1:0] delay_s, duration_s;
    logic        [HPW-1:0] half_period_s;
    logic signed [DWT-1:0] amp_s;
    logic                  bipolar_s;

    logic                  enable_reg, bipolar_reg, trig_q;
    logic        [MEM-1:0] delay_reg, duration_reg, holdoff_reg;
    logic        [HPW-1:0] half_period_reg;
    logic signed [DWT-1:0] amplitude_reg;
    logic        [MEM-1:0] fired_cnt_reg, dropped_cnt_reg;
    logic        [MEM-1:0] fired_next, dropped_next;

    logic [19:0] addr;
    logic        req, fire_entry, drop, clr_fired, clr_dropped;
    logic [31:0] rdata_next;
    logic [35:0] unused_bits;

    assign addr        = sys_addr[19:0];
    assign unused_bits = {sys_sel, sys_addr[31:20], sys_wdata[31:12]};
    assign busy_o      = (state_reg != ST_IDLE);
    assign sys_err     = 1'b0;

    always_comb begin
        req         = (sort_trig_i && !trig_q)
                    || (sys_wen && addr == REG_CTRL && sys_wdata[1]);
        fire_entry  = enable_reg && state_reg == ST_DELAY
                    && tmr_reg == delay_s && duration_s != '0;
        drop        = req && enable_reg && state_reg != ST_IDLE;
        clr_fired   = sys_wen && addr == REG_FIRED_CNT;
        clr_dropped = sys_wen && addr == REG_DROPPED_CNT;

        // A clear coinciding with an increment leaves exactly one event.
        fired_next = fired_cnt_reg;
        if (clr_fired)
            fired_next = fire_entry ? ONE : '0;
        else if (fire_entry && fired_cnt_reg != '1)
            fired_next = fired_cnt_reg + ONE;

        dropped_next = dropped_cnt_reg;
        if (clr_dropped)
            dropped_next = drop ? ONE : '0;
        else if (drop && dropped_cnt_reg != '1)
            dropped_next = dropped_cnt_reg + ONE;

        rdata_next = '0;
        case (addr)
            REG_CTRL:        rdata_next = 32'({bipolar_reg, 1'b0, enable_reg});
            REG_DELAY:       rdata_next = 32'(delay_reg);
            REG_DURATION:    rdata_next = 32'(duration_reg);
            REG_HALF_PERIOD: rdata_next = 32'(half_period_reg);
            REG_AMPLITUDE:   rdata_next = 32'(amplitude_reg);
            REG_HOLDOFF:     rdata_next = 32'(holdoff_reg);
            REG_FIRED_CNT:   rdata_next = 32'(fired_cnt_reg);
            REG_DROPPED_CNT: rdata_next = 32'(dropped_cnt_reg);
            REG_STATUS:      rdata_next = 32'({busy_o, state_reg});
            default:         rdata_next = '0;
        endcase
    end

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            state_reg     <= ST_IDLE;
            tmr_reg       <= '0;
            delay_s       <= '0;
            duration_s    <= '0;
            half_period_s <= '0;
            amp_s         <= '0;
            bipolar_s     <= 1'b0;
        end else if (state_reg != ST_IDLE && !enable_reg) begin
            state_reg <= ST_IDLE;
            tmr_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: if (req && enable_reg) begin
                    delay_s       <= delay_reg;
                    duration_s    <= duration_reg;
                    half_period_s <= half_period_reg;
                    amp_s         <= amplitude_reg;
                    bipolar_s     <= bipolar_reg;
                    tmr_reg       <= '0;
                    state_reg     <= ST_DELAY;
                end
                ST_DELAY: if (tmr_reg == delay_s) begin
                    tmr_reg   <= '0;
                    state_reg <= (duration_s == '0) ? ST_HOLDOFF : ST_FIRE;
                end else begin
                    tmr_reg <= tmr_reg + ONE;
                end
                ST_FIRE: if (tmr_reg == duration_s - ONE) begin
                    tmr_reg   <= '0;
                    state_reg <= ST_HOLDOFF;
                end else begin
                    tmr_reg <= tmr_reg + ONE;
                end
                ST_HOLDOFF: if (holdoff_reg == '0 || tmr_reg == holdoff_reg - ONE) begin
                    tmr_reg   <= '0;
                    state_reg <= ST_IDLE;
                end else begin
                    tmr_reg <= tmr_reg + ONE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            enable_reg      <= 1'b0;
            bipolar_reg     <= 1'b0;
            delay_reg       <= '0;
            duration_reg    <= MEM'(DEF_DURATION);
            half_period_reg <= HPW'(DEF_HALF_PERIOD);
            amplitude_reg   <= '0;
            holdoff_reg     <= MEM'(DEF_HOLDOFF);
            fired_cnt_reg   <= '0;
            dropped_cnt_reg <= '0;
            trig_q          <= 1'b0;
            sys_ack         <= 1'b0;
            sys_rdata       <= '0;
        end else begin
            trig_q          <= sort_trig_i;
            sys_ack         <= sys_wen || sys_ren;
            sys_rdata       <= rdata_next;
            fired_cnt_reg   <= fired_next;
            dropped_cnt_reg <= dropped_next;
            if (sys_wen) begin
                case (addr)
                    REG_CTRL: begin
                        enable_reg  <= sys_wdata[0];
                        bipolar_reg <= sys_wdata[2];
                    end
                    REG_DELAY:       delay_reg       <= sys_wdata[MEM-1:0];
                    REG_DURATION:    duration_reg    <= sys_wdata[MEM-1:0];
                    REG_HALF_PERIOD: half_period_reg <= sys_wdata[HPW-1:0];
                    REG_AMPLITUDE:   amplitude_reg   <= sys_wdata[DWT-1:0];
                    REG_HOLDOFF:     holdoff_reg     <= sys_wdata[MEM-1:0];
                    default: ;
                endcase
            end
        end
    end

    red_pitaya_fads_burst_gen #(
        .DWT(DWT),
        .HPW(HPW)
    ) u_burst_gen (
        .clk         (adc_clk_i),
        .rstn        (adc_rstn_i),
        .run         (state_reg == ST_FIRE && enable_reg),
        .amp         (amp_s),
        .half_period (half_period_s),
        .bipolar     (bipolar_s),
        .sample      (dac_o)
    );

endmodule

// File: tb/tb_red_pitaya_fads_sort_pulse.sv
// Directed bench for the sort-pulse actuator; each task covers one scenario
// with hand-derived expected values.
module tb_red_pitaya_fads_sort_pulse;

    logic               adc_clk_i = 1'b0;
    logic               adc_rstn_i = 1'b0;
    logic               sort_trig_i = 1'b0;
    logic signed [13:0] dac_o;
    logic               busy_o;
    logic        [31:0] sys_addr = '0;
    logic        [31:0] sys_wdata = '0;
    logic         [3:0] sys_sel = 4'hF;
    logic               sys_wen = 1'b0;
    logic               sys_ren = 1'b0;
    logic        [31:0] sys_rdata;
    logic               sys_err;
    logic               sys_ack;

    int n_tests = 0;
    int n_fail  = 0;

    red_pitaya_fads_sort_pulse dut (
        .adc_clk_i   (adc_clk_i),
        .adc_rstn_i  (adc_rstn_i),
        .sort_trig_i (sort_trig_i),
        .dac_o       (dac_o),
        .busy_o      (busy_o),
        .sys_addr    (sys_addr),
        .sys_wdata   (sys_wdata),
        .sys_sel     (sys_sel),
        .sys_wen     (sys_wen),
        .sys_ren     (sys_ren),
        .sys_rdata   (sys_rdata),
        .sys_err     (sys_err),
        .sys_ack     (sys_ack)
    );

    always #5 adc_clk_i = ~adc_clk_i;

    task automatic tick();
        @(posedge adc_clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        tick();
        sys_wen = 1'b0;
        $display("[TB] wr 0x%02h <= 0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sys_addr = a; sys_ren = 1'b1;
        tick();
        sys_ren = 1'b0;
        d = sys_rdata;
        $display("[TB] rd 0x%02h => 0x%08h", a, d);
    endtask

    task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        n_tests++;
        if (d !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, d, exp);
        end
    endtask

    task automatic test_defaults(input string tag);
        logic [31:0] addrs[8] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
        logic [31:0] exps[8]  = '{32'd0, 32'd0, 32'd1000, 32'd50, 32'd0, 32'd1000, 32'd0, 32'd0};
        for (int i = 0; i < 8; i++)
            check_reg($sformatf("%s_reg%02h", tag, addrs[i]), addrs[i], exps[i]);
    endtask

    task automatic test_reset();
        adc_rstn_i = 1'b0;
        sys_ren = 1'b1;
        tick(); tick();
        n_tests++;
        if ({dac_o, busy_o, sys_ack, sys_err, sys_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: dac=%0d busy=%b ack=%b err=%b rdata=%h want all 0",
                     dac_o, busy_o, sys_ack, sys_err, sys_rdata);
        end
        sys_ren = 1'b0;
        adc_rstn_i = 1'b1;
        tick();
        test_defaults("reset");
    endtask

    task automatic test_bus();
        logic [31:0] d;
        bus_write(32'h04, 32'd7);
        bus_read(32'h04, d);
        n_tests++;
        if (sys_ack !== 1'b1 || d !== 32'd7) begin
            n_fail++;
            $display("FAIL bus_readback: ack=%b rdata=%0d want ack=1 rdata=7", sys_ack, d);
        end
        tick();
        n_tests++;
        if (sys_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_ack_drop: ack=%b want 0", sys_ack);
        end
        check_reg("bus_unmapped", 32'h40, 32'd0);
        bus_write(32'h00, 32'h7);
        check_reg("bus_ctrl_sw_reads0", 32'h00, 32'h5);
        check_reg("bus_status_idle", 32'h20, 32'h0);
        bus_write(32'h00, 32'h0);
        bus_write(32'h04, 32'd0);
    endtask

    task automatic config_pulse();
        bus_write(32'h04, 32'd10);
        bus_write(32'h08, 32'd20);
        bus_write(32'h0C, 32'd5);
        bus_write(32'h10, 32'd1000);
        bus_write(32'h14, 32'd8);
        bus_write(32'h00, 32'h5);
    endtask

    // delay=10, duration=20, half=5, amp=1000, holdoff=8: samples on edges k+12..k+31,
    // HOLDOFF from k+31, IDLE at k+39. Extra hw edges are raised after cycles t1/t2.
    task automatic pulse_run(input bit use_sw, input int t1, input int t2, input string tag);
        logic signed [13:0] exp;
        logic               exp_busy;
        if (use_sw) begin
            sys_addr = 32'h00; sys_wdata = 32'h7; sys_wen = 1'b1;
        end else begin
            sort_trig_i = 1'b1;
        end
        tick();
        sys_wen = 1'b0;
        sort_trig_i = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            exp = '0;
            if (i >= 12 && i <= 31)
                exp = ((((i - 12) / 5) % 2) == 0) ? 14'sd1000 : -14'sd1000;
            exp_busy = (i < 39);
            n_tests++;
            if (dac_o !== exp || busy_o !== exp_busy) begin
                n_fail++;
                $display("FAIL %s_k+%0d: dac=%0d busy=%b want dac=%0d busy=%b",
                         tag, i, dac_o, busy_o, exp, exp_busy);
            end
            sort_trig_i = (i == t1 || i == t2);
        end
        sort_trig_i = 1'b0;
        tick();
    endtask

    task automatic test_basic_pulse();
        config_pulse();
        pulse_run(1'b0, -1, -1, "basic");
        check_reg("basic_fired", 32'h18, 32'd1);
        check_reg("basic_dropped", 32'h1C, 32'd0);
    endtask

    task automatic test_dropped();
        bus_write(32'h18, 32'd0);
        bus_write(32'h1C, 32'd0);
        pulse_run(1'b0, 15, 34, "drop");
        check_reg("drop_dropped", 32'h1C, 32'd2);
        check_reg("drop_fired", 32'h18, 32'd1);
    endtask

    task automatic test_sw_trig();
        bus_write(32'h18, 32'd0);
        bus_write(32'h1C, 32'd0);
        pulse_run(1'b1, -1, -1, "swtrig");
        check_reg("swtrig_fired", 32'h18, 32'd1);
    endtask

    // amp=-8192, half=0, duration=4, delay=0: samples on edges k+2..k+5.
    task automatic test_saturation(input bit bipolar);
        logic signed [13:0] seq[4];
        logic signed [13:0] exp;
        if (bipolar) seq = '{-14'sd8192, 14'sd8191, -14'sd8192, 14'sd8191};
        else         seq = '{-14'sd8192, 14'sd0, -14'sd8192, 14'sd0};
        bus_write(32'h04, 32'd0);
        bus_write(32'h08, 32'd4);
        bus_write(32'h0C, 32'd0);
        bus_write(32'h10, 32'h2000);
        bus_write(32'h14, 32'd2);
        bus_write(32'h00, bipolar ? 32'h5 : 32'h1);
        sort_trig_i = 1'b1;
        tick();
        sort_trig_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp = (i >= 2 && i <= 5) ? seq[i-2] : 14'sd0;
            n_tests++;
            if (dac_o !== exp) begin
                n_fail++;
                $display("FAIL sat_bip%0d_k+%0d: dac=%0d want %0d", bipolar, i, dac_o, exp);
            end
        end
    endtask

    task automatic test_clear_on_fire();
        bus_write(32'h04, 32'd0);
        bus_write(32'h08, 32'd2);
        sort_trig_i = 1'b1;
        tick();
        sort_trig_i = 1'b0;
        bus_write(32'h18, 32'd0);
        repeat (8) tick();
        check_reg("clr_on_fire_fired", 32'h18, 32'd1);
    endtask

    task automatic start_long_burst();
        bus_write(32'h04, 32'd0);
        bus_write(32'h08, 32'd20);
        bus_write(32'h0C, 32'd5);
        bus_write(32'h10, 32'd1000);
        bus_write(32'h14, 32'd8);
        bus_write(32'h00, 32'h5);
        bus_write(32'h18, 32'd0);
        bus_write(32'h1C, 32'd0);
        sort_trig_i = 1'b1;
        tick();
        sort_trig_i = 1'b0;
        tick(); tick();
        n_tests++;
        if (dac_o !== 14'sd1000) begin
            n_fail++;
            $display("FAIL abort_prefire: dac=%0d want 1000", dac_o);
        end
    endtask

    task automatic test_abort_enable();
        start_long_burst();
        bus_write(32'h00, 32'h0);
        n_tests++;
        if (dac_o !== 14'sd1000) begin
            n_fail++;
            $display("FAIL abort_en_write_edge: dac=%0d want 1000", dac_o);
        end
        tick();
        n_tests++;
        if (dac_o !== 14'sd0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_en_next: dac=%0d busy=%b want 0 0", dac_o, busy_o);
        end
        check_reg("abort_en_status", 32'h20, 32'h0);
        sort_trig_i = 1'b1;
        tick();
        sort_trig_i = 1'b0;
        tick();
        check_reg("abort_en_fired", 32'h18, 32'd1);
        check_reg("abort_en_disabled_no_drop", 32'h1C, 32'd0);
    endtask

    task automatic test_abort_reset();
        start_long_burst();
        adc_rstn_i = 1'b0;
        tick();
        n_tests++;
        if (dac_o !== 14'sd0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_rst: dac=%0d busy=%b want 0 0", dac_o, busy_o);
        end
        adc_rstn_i = 1'b1;
        tick();
        test_defaults("abort_rst");
    endtask

    initial begin
        test_reset();
        test_bus();
        test_basic_pulse();
        test_dropped();
        test_sw_trig();
        test_saturation(1'b0);
        test_saturation(1'b1);
        test_clear_on_fire();
        test_abort_enable();
        test_abort_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
